// File: rtl/status_readback_if.sv
// Host register read/write bus for status_readback.
// The host drives the request signals; the block returns registered read data.
interface status_readback_if;
  logic [10:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic        xfc;
  logic [7:0]  rdata;
  logic        rdata_valid;

  modport master (
    output address, wdata, we, re, xfc,
    input  rdata, rdata_valid
  );

  modport slave (
    input  address, wdata, we, re, xfc,
    output rdata, rdata_valid
  );
endinterface

// File: rtl/status_readback.sv
// Status/counter/irq readback for I2S FIFO events: sticky W1C flags,
// saturating clear-on-read counters, interrupt enables and a level irq.
module status_readback #(
  parameter logic [10:0] STATUS_ADDR = 11'h00C,
  parameter logic [10:0] CNT0_ADDR   = 11'h00D,
  parameter logic [10:0] CNT1_ADDR   = 11'h00E,
  parameter logic [10:0] IEN_ADDR    = 11'h00F,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  status_readback_if.slave  bus,
  input  logic              i2si_fifo_overrun,
  input  logic              i2so_fifo_underrun,
  output logic              irq
);

  localparam int unsigned     DATA_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              hist0_q, hist2_q;
  logic              flag0_q, flag2_q;
  logic              ien0_q, ien2_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              irq_q;

  logic              ev0_c, ev2_c;
  logic              wr_op_c, rd_op_c;
  logic              flag0_nxt_c, flag2_nxt_c;
  logic              ien0_nxt_c, ien2_nxt_c;
  logic [CNT_W-1:0]  cnt0_nxt_c, cnt1_nxt_c;
  logic [DATA_W-1:0] rdata_c;

  // Only bits 0 and 2 of the write data are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[7:3], bus.wdata[1]};

  // Read clears to zero, or to one if an event lands in the same cycle.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             ev,
    input logic             clr
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr)
      res = ev ? CNT_W'(1) : '0;
    else if (ev && (cnt != CNT_MAX))
      res = cnt + CNT_W'(1);
    return res;
  endfunction

  always_comb begin
    ev0_c       = i2si_fifo_overrun  & ~hist0_q;
    ev2_c       = i2so_fifo_underrun & ~hist2_q;
    wr_op_c     = bus.xfc & bus.we;
    rd_op_c     = bus.xfc & bus.re & ~bus.we;

    flag0_nxt_c = flag0_q;
    flag2_nxt_c = flag2_q;
    ien0_nxt_c  = ien0_q;
    ien2_nxt_c  = ien2_q;
    rdata_c     = '0;

    // Set dominates a simultaneous write-1-to-clear.
    if (wr_op_c && (bus.address == STATUS_ADDR)) begin
      flag0_nxt_c = flag0_q & ~bus.wdata[0];
      flag2_nxt_c = flag2_q & ~bus.wdata[2];
    end
    if (ev0_c) flag0_nxt_c = 1'b1;
    if (ev2_c) flag2_nxt_c = 1'b1;

    if (wr_op_c && (bus.address == IEN_ADDR)) begin
      ien0_nxt_c = bus.wdata[0];
      ien2_nxt_c = bus.wdata[2];
    end

    cnt0_nxt_c = cnt_next(cnt0_q, ev0_c, rd_op_c && (bus.address == CNT0_ADDR));
    cnt1_nxt_c = cnt_next(cnt1_q, ev2_c, rd_op_c && (bus.address == CNT1_ADDR));

    unique case (bus.address)
      STATUS_ADDR: rdata_c = {5'b0, flag2_q, 1'b0, flag0_q};
      IEN_ADDR:    rdata_c = {5'b0, ien2_q, 1'b0, ien0_q};
      CNT0_ADDR:   rdata_c = DATA_W'(cnt0_q);
      CNT1_ADDR:   rdata_c = DATA_W'(cnt1_q);
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist0_q       <= 1'b0;
      hist2_q       <= 1'b0;
      flag0_q       <= 1'b0;
      flag2_q       <= 1'b0;
      ien0_q        <= 1'b0;
      ien2_q        <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      hist0_q       <= i2si_fifo_overrun;
      hist2_q       <= i2so_fifo_underrun;
      flag0_q       <= flag0_nxt_c;
      flag2_q       <= flag2_nxt_c;
      ien0_q        <= ien0_nxt_c;
      ien2_q        <= ien2_nxt_c;
      cnt0_q        <= cnt0_nxt_c;
      cnt1_q        <= cnt1_nxt_c;
      rdata_valid_q <= rd_op_c;
      if (rd_op_c) rdata_q <= rdata_c;
      irq_q         <= (flag0_q & ien0_q) | (flag2_q & ien2_q);
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_status_readback.sv
// Scoreboard bench for status_readback: expected read data is queued when a
// read is issued and popped when the result cycle is sampled.
module tb_status_readback;

  localparam logic [10:0] A_STAT = 11'h00C;
  localparam logic [10:0] A_CNT0 = 11'h00D;
  localparam logic [10:0] A_CNT1 = 11'h00E;
  localparam logic [10:0] A_IEN  = 11'h00F;
  localparam logic [10:0] A_NONE = 11'h123;

  logic clk = 1'b0;
  logic rst;
  logic ovr, und, irq;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  status_readback_if bus();

  status_readback dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .i2si_fifo_overrun  (ovr),
    .i2so_fifo_underrun (und),
    .irq                (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.address = '0;
    bus.wdata   = '0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.xfc     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus_idle();
      @(negedge clk);
    end
  endtask

  task automatic write_op(input logic [10:0] a, input logic [7:0] d);
    bus.address = a;
    bus.wdata   = d;
    bus.we      = 1'b1;
    bus.re      = 1'b0;
    bus.xfc     = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  // Issues one read, queues its expectation, returns the result-cycle sample.
  task automatic read_op(input logic [10:0] a, input logic [7:0] e,
                         output logic [7:0] got, output logic vld);
    bus.address = a;
    bus.we      = 1'b0;
    bus.re      = 1'b1;
    bus.xfc     = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus_idle();
    got = bus.rdata;
    vld = bus.rdata_valid;
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    logic vld;
    rst = 1'b1; ovr = 1'b0; und = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    total++;
    if (bus.rdata !== 8'h00 || bus.rdata_valid !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rdata=%h valid=%b irq=%b, need 00/0/0", bus.rdata, bus.rdata_valid, irq);
    end
    rst = 1'b0;
    idle(1);
    read_op(A_STAT, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_status_read: rdata=%h valid=%b irq=%b, need %h/1/0", got, vld, irq, e);
    end
    read_op(A_NONE, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL unmapped_read: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
  endtask

  task automatic test_overrun_count();
    logic [7:0] got, e;
    logic vld;
    ovr = 1'b1;
    idle(5);
    ovr = 1'b0;
    idle(1);
    read_op(A_CNT0, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt0_held_level: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    idle(1);
    total++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== 8'h01) begin
      bad++;
      $display("FAIL rdata_hold: rdata=%h valid=%b, need 01/0", bus.rdata, bus.rdata_valid);
    end
    read_op(A_CNT0, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt0_clear_on_read: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_STAT, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL status_flag0: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    write_op(A_STAT, 8'h01);
  endtask

  task automatic test_saturation();
    logic [7:0] got, e;
    logic vld;
    for (int i = 0; i < 300; i++) begin
      und = 1'b1;
      idle(1);
      und = 1'b0;
      idle(1);
    end
    read_op(A_CNT1, 8'hFF, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt1_saturate: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_STAT, 8'h04, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL status_flag2: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_CNT1, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt1_clear_after_sat: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
  endtask

  task automatic test_irq();
    logic [7:0] got, e;
    logic vld;
    write_op(A_STAT, 8'h04);
    write_op(A_IEN, 8'h04);
    idle(1);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_idle: irq=%b, need 0", irq);
    end
    und = 1'b1;
    idle(1);
    und = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_flag_cycle: irq=%b, need 0", irq);
    end
    idle(1);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_assert: irq=%b, need 1", irq);
    end
    write_op(A_STAT, 8'h04);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_clear_cycle: irq=%b, need 1", irq);
    end
    idle(1);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_deassert: irq=%b, need 0", irq);
    end
    read_op(A_IEN, 8'h04, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL ien_read: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_CNT1, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt1_single: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, e;
    logic vld;
    ovr = 1'b1;
    write_op(A_STAT, 8'h01);
    ovr = 1'b0;
    read_op(A_STAT, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL w1c_vs_set: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    ovr = 1'b1;
    read_op(A_CNT0, 8'h01, got, vld);
    ovr = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt_read_vs_event: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_CNT0, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt_after_read_event: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    write_op(A_STAT, 8'h01);
    ovr = 1'b1;
    read_op(A_STAT, 8'h00, got, vld);
    ovr = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL status_read_vs_event: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_STAT, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL status_after_event: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
  endtask

  task automatic test_ops_and_reset();
    logic [7:0] got, e;
    logic vld;
    bus.address = A_CNT0;
    bus.wdata   = 8'hFF;
    bus.we      = 1'b1;
    bus.re      = 1'b1;
    bus.xfc     = 1'b1;
    @(negedge clk);
    bus_idle();
    total++;
    if (bus.rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL we_re_no_valid: valid=%b, need 0", bus.rdata_valid);
    end
    bus.address = A_CNT0;
    bus.re      = 1'b1;
    bus.xfc     = 1'b0;
    @(negedge clk);
    bus_idle();
    total++;
    if (bus.rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_xfc_no_valid: valid=%b, need 0", bus.rdata_valid);
    end
    read_op(A_CNT0, 8'h01, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt0_untouched: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_IEN, 8'h04, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL ien_before_reset: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    bus.address = A_STAT;
    bus.re      = 1'b1;
    bus.xfc     = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    bus_idle();
    total++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== 8'h00 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_read: rdata=%h valid=%b irq=%b, need 00/0/0", bus.rdata, bus.rdata_valid, irq);
    end
    rst = 1'b0;
    idle(1);
    read_op(A_STAT, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL status_after_reset: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_IEN, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL ien_after_reset: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
    read_op(A_CNT0, 8'h00, got, vld);
    e = exp_q.pop_front();
    total++;
    if (vld !== 1'b1 || got !== e) begin
      bad++;
      $display("FAIL cnt0_after_reset: rdata=%h valid=%b, need %h/1", got, vld, e);
    end
  endtask

  initial begin
    test_reset();
    test_overrun_count();
    test_saturation();
    test_irq();
    test_simultaneous();
    test_ops_and_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
